alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_sequencer_pkg.sv | 42 ++++
 rtl/alarm_sequencer_if.sv | 27 ++
 rtl/alarm_sequencer_tone_gen.sv | 53 +++++
 rtl/alarm_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alarm_pkg
//   Shared types and constants for the alarm sequencer:
//     state_t        sequencer states (IDLE, CHIME, ALARM, SNOOZE)
//     alarm_entry_t  one alarm table entry (hour, minute, enable)
//     MELODY_W       width of one melody note (half-period in clk cycles)
//     MELODY_LEN     number of notes in the alarm melody
//     MELODY         melody table, one note per second, 0 = rest
//     idx_width()    index width for a table of n entries (at least 1 bit)
// ---------------------------------------------------------------------------
package alarm_pkg;

    localparam int MELODY_W   = 20;
    localparam int MELODY_LEN = 19;

    typedef logic [MELODY_W-1:0] note_t;

    localparam note_t MELODY [MELODY_LEN] = '{
        20'd113636, 20'd170300, 20'd151700, 20'd191131, 20'd191131,
        20'd0,      20'd191131, 20'd143184, 20'd113636, 20'd170300,
        20'd0,      20'd191131, 20'd191131, 20'd0,      20'd191131,
        20'd191131, 20'd0,      20'd191131, 20'd191131
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHIME,
        ST_ALARM,
        ST_SNOOZE
    } state_t;

    typedef struct packed {
        logic [5:0] hour;
        logic [5:0] min;
        logic       en;
    } alarm_entry_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// ---------------------------------------------------------------------------
// alarm_sequencer_if
//   Alarm table configuration bus.
//     cfg_we    write strobe, entry is written on the following clk edge
//     cfg_idx   entry index
//     cfg_hour  alarm hour (0..23)
//     cfg_min   alarm minute (0..59)
//     cfg_en    entry enable
//   master: drives the bus (host / testbench); slave: alarm_sequencer.
// ---------------------------------------------------------------------------
interface alarm_sequencer_if
    import alarm_pkg::*;
#(
    parameter int N_ALARMS = 4
);
    localparam int IDX_W = idx_width(N_ALARMS);

    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [5:0]       cfg_hour;
    logic [5:0]       cfg_min;
    logic             cfg_en;

    modport master (output cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_en);
    modport slave  (input  cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_en);

endinterface

// File: rtl/alarm_sequencer_tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen
//   Square-wave buzzer driver. speak toggles every `period` clk cycles; the
//   half-period counter restarts whenever period changes. Silent when
//   period == 0 or on == 0.
//     clk, rst  clock, asynchronous active-high reset
//     period    half-period in clk cycles, 0 = silence
//     on        output enable
//     speak     buzzer drive
// ---------------------------------------------------------------------------
module tone_gen #(
    parameter int NOTE_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] period,
    input  logic              on,
    output logic              speak
);

    logic [NOTE_W-1:0] prev_q;
    logic [NOTE_W-1:0] cnt_q;
    logic              tog_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q  <= '0;
            tog_q  <= 1'b0;
        end else begin
            prev_q <= period;
            if (period == '0) begin
                cnt_q <= '0;
                tog_q <= 1'b0;
            end else if (period != prev_q) begin
                // New note: start a fresh half-period from the low phase.
                cnt_q <= period - 1'b1;
                tog_q <= 1'b0;
            end else if (cnt_q == '0) begin
                cnt_q <= period - 1'b1;
                tog_q <= ~tog_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Gated combinationally so reset or on=0 silences the buzzer at once.
    assign speak = tog_q & on & (period != '0);

endmodule

// File: rtl/alarm_sequencer.sv
// ---------------------------------------------------------------------------
// alarm_sequencer
//   Alarm clock sequencer: hourly chime, N_ALARMS programmable alarms with a
//   melody, snooze and auto-stop. Time advances on sec_tick.
//     clk, rst      clock (100 MHz), asynchronous active-high reset
//     on            buzzer output enable (sequencing continues when 0)
//     sec_tick      one-cycle pulse per second, time inputs valid with it
//     hour/min/sec  current time
//     cfg           alarm table write bus (alarm_sequencer_if.slave)
//     snooze, stop  one-cycle button pulses
//     speak         buzzer drive
//     period        current half-period, 0 = silence (registered)
//     alarm_active  high while ringing; snoozing high while snoozed
//     active_idx    channel ringing or snoozed
// ---------------------------------------------------------------------------
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int N_ALARMS     = 4,
    parameter int NOTE_W       = 20,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_RING_SEC = 60,
    parameter int CHIME_PERIOD = 20000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             on,
    input  logic                             sec_tick,
    input  logic [5:0]                       hour,
    input  logic [5:0]                       min,
    input  logic [5:0]                       sec,
    alarm_sequencer_if.slave                 cfg,
    input  logic                             snooze,
    input  logic                             stop,
    output logic                             speak,
    output logic [NOTE_W-1:0]                period,
    output logic                             alarm_active,
    output logic                             snoozing,
    output logic [idx_width(N_ALARMS)-1:0]   active_idx
);

    localparam int IDX_W  = idx_width(N_ALARMS);
    localparam int STEP_W = $clog2(MELODY_LEN);
    localparam int RING_W = $clog2(MAX_RING_SEC + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);

    alarm_entry_t alarm_tbl_q [N_ALARMS];

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [RING_W-1:0]   ring_q, ring_d;
    logic [SNZ_W-1:0]    snz_q, snz_d;
    logic [4:0]          chime_step_q, chime_step_d;
    logic [4:0]          chime_last_q, chime_last_d;
    logic [NOTE_W-1:0]   period_q, period_d;

    logic                match;
    logic [IDX_W-1:0]    match_idx;
    logic [5:0]          beeps;
    logic [4:0]          chime_last_new;
    logic                start_alarm;
    logic [IDX_W-1:0]    start_idx;

    // ---------------- alarm table ----------------
    // NOTE: the table is small and must come up disabled, so it is reset
    // like ordinary flops rather than inferred as a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ALARMS; i++) alarm_tbl_q[i] <= '0;
        end else if (cfg.cfg_we && (int'(cfg.cfg_idx) < N_ALARMS)) begin
            alarm_tbl_q[cfg.cfg_idx] <= '{hour: cfg.cfg_hour, min: cfg.cfg_min, en: cfg.cfg_en};
        end
    end

    // Scan from the top so the lowest matching index is the one that sticks.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alarm_tbl_q[i].en && alarm_tbl_q[i].hour == hour &&
                alarm_tbl_q[i].min == min) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
        match = match && (sec == 6'd0);
    end

    // Chime beeps = hour mod 12 (0 -> 12); beep/rest steps run 0 .. 2*beeps-2.
    always_comb begin
        beeps = (hour >= 6'd12) ? hour - 6'd12 : hour;
        if (beeps == 6'd0) beeps = 6'd12;
        chime_last_new = 5'((beeps << 1) - 6'd2);
    end

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            step_q       <= '0;
            ring_q       <= '0;
            snz_q        <= '0;
            chime_step_q <= '0;
            chime_last_q <= '0;
            period_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            ring_q       <= ring_d;
            snz_q        <= snz_d;
            chime_step_q <= chime_step_d;
            chime_last_q <= chime_last_d;
            period_q     <= period_d;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        step_d       = step_q;
        ring_d       = ring_q;
        snz_d        = snz_q;
        chime_step_d = chime_step_q;
        chime_last_d = chime_last_q;
        start_alarm  = 1'b0;
        start_idx    = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sec_tick && match) begin
                    start_alarm = 1'b1;
                    start_idx   = match_idx;
                end else if (sec_tick && min == 6'd0 && sec == 6'd0) begin
                    state_d      = ST_CHIME;
                    chime_step_d = '0;
                    chime_last_d = chime_last_new;
                end
            end
            ST_CHIME: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (sec_tick && match) begin
                    start_alarm = 1'b1;
                    start_idx   = match_idx;
                end else if (sec_tick) begin
                    if (chime_step_q == chime_last_q) state_d = ST_IDLE;
                    else                              chime_step_d = chime_step_q + 1'b1;
                end
            end
            ST_ALARM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (snooze) begin
                    state_d = ST_SNOOZE;
                    snz_d   = SNZ_W'(SNOOZE_SEC);
                end else if (sec_tick) begin
                    if (ring_q == RING_W'(MAX_RING_SEC - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_d = ring_q + 1'b1;
                        step_d = (step_q == STEP_W'(MELODY_LEN - 1)) ? '0 : step_q + 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (sec_tick && match) begin
                    start_alarm = 1'b1;
                    start_idx   = match_idx;
                end else if (sec_tick) begin
                    if (snz_q == SNZ_W'(1)) start_alarm = 1'b1;
                    else                    snz_d = snz_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_alarm) begin
            state_d = ST_ALARM;
            idx_d   = start_idx;
            step_d  = '0;
            ring_d  = '0;
        end

        // Period follows the state being entered, so it is valid one clk
        // after the tick or button that caused the change.
        unique case (state_d)
            ST_ALARM: period_d = NOTE_W'(MELODY[step_d]);
            ST_CHIME: period_d = chime_step_d[0] ? '0 : NOTE_W'(CHIME_PERIOD);
            default:  period_d = '0;
        endcase
    end

    assign period       = period_q;
    assign alarm_active = (state_q == ST_ALARM);
    assign snoozing     = (state_q == ST_SNOOZE);
    assign active_idx   = idx_q;

    tone_gen #(.NOTE_W(NOTE_W)) u_tone_gen (
        .clk    (clk),
        .rst    (rst),
        .period (period_q),
        .on     (on),
        .speak  (speak)
    );

endmodule

// File: tb/tb_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alarm_sequencer
//   Directed bench for alarm_sequencer with default parameters. Inputs are
//   driven and outputs sampled on the falling clock edge; each sec_tick is a
//   single-cycle pulse so a full snooze / ring timeout stays short.
// ---------------------------------------------------------------------------
module tb_alarm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        on;
    logic        sec_tick;
    logic [5:0]  hour, min, sec;
    logic        snooze, stop;
    logic        speak;
    logic [19:0] period;
    logic        alarm_active, snoozing;
    logic [1:0]  active_idx;

    int n_total = 0;
    int n_pass  = 0;

    alarm_sequencer_if #(.N_ALARMS(4)) cfg_if ();

    alarm_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .on           (on),
        .sec_tick     (sec_tick),
        .hour         (hour),
        .min          (min),
        .sec          (sec),
        .cfg          (cfg_if),
        .snooze       (snooze),
        .stop         (stop),
        .speak        (speak),
        .period       (period),
        .alarm_active (alarm_active),
        .snoozing     (snoozing),
        .active_idx   (active_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_at(input int h, input int m, input int s);
        hour     = 6'(h);
        min      = 6'(m);
        sec      = 6'(s);
        sec_tick = 1'b1;
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic press(input logic s, input logic t);
        snooze = s;
        stop   = t;
        @(negedge clk);
        snooze = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input int h, input int m, input logic en);
        cfg_if.cfg_we   = 1'b1;
        cfg_if.cfg_idx  = 2'(idx);
        cfg_if.cfg_hour = 6'(h);
        cfg_if.cfg_min  = 6'(m);
        cfg_if.cfg_en   = en;
        @(negedge clk);
        cfg_if.cfg_we   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; on = 1'b1; sec_tick = 1'b0;
        hour = '0; min = '0; sec = '0; snooze = 1'b0; stop = 1'b0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_idx = '0;
        cfg_if.cfg_hour = '0; cfg_if.cfg_min = '0; cfg_if.cfg_en = 1'b0;

        // Reset state
        cycles(3);
        check("rst_period", period, 0);
        check("rst_speak", speak, 0);
        check("rst_active", alarm_active, 0);
        check("rst_snoozing", snoozing, 0);
        check("rst_idx", active_idx, 0);
        rst = 1'b0;
        cycles(2);

        // Empty table: no alarm at 07:30:00
        tick_at(7, 30, 0);
        check("empty_active", alarm_active, 0);
        check("empty_period", period, 0);

        // Entry0 07:30: melody starts, advances per tick
        cfg_write(0, 7, 30, 1'b1);
        tick_at(7, 30, 0);
        check("a0_active", alarm_active, 1);
        check("a0_idx", active_idx, 0);
        check("a0_step0", period, 113636);
        tick_at(7, 30, 1);
        check("a0_step1", period, 170300);
        tick_at(7, 30, 2);
        check("a0_step2", period, 151700);
        tick_at(7, 30, 3);
        check("a0_step3", period, 191131);

        // Snooze at step 3, restart after 300 ticks at step 0
        press(1'b1, 1'b0);
        check("snz_period", period, 0);
        check("snz_flag", snoozing, 1);
        check("snz_active", alarm_active, 0);
        for (int i = 0; i < 299; i++) tick_at(7, 31, 1);
        check("snz_299", snoozing, 1);
        tick_at(7, 31, 1);
        check("snz_300_active", alarm_active, 1);
        check("snz_300_period", period, 113636);
        check("snz_300_idx", active_idx, 0);

        // Unattended ring: 59 more ticks still ringing (step 59 mod 19 = 2),
        // the 60th stops it
        for (int i = 0; i < 59; i++) tick_at(7, 36, 1);
        check("ring59_active", alarm_active, 1);
        check("ring59_period", period, 151700);
        tick_at(7, 37, 1);
        check("ring60_active", alarm_active, 0);
        check("ring60_period", period, 0);

        // stop + snooze together -> IDLE
        tick_at(7, 30, 0);
        check("both_pre", alarm_active, 1);
        press(1'b1, 1'b1);
        check("both_active", alarm_active, 0);
        check("both_snoozing", snoozing, 0);
        check("both_period", period, 0);

        // stop while snoozed -> IDLE
        tick_at(7, 30, 0);
        press(1'b1, 1'b0);
        check("snzstop_pre", snoozing, 1);
        press(1'b0, 1'b1);
        check("snzstop_snoozing", snoozing, 0);
        check("snzstop_period", period, 0);

        // Hourly chime at 04:00:00: four beeps over seven ticks
        tick_at(4, 0, 0);
        check("chime_t0", period, 20000);
        check("chime_active", alarm_active, 0);
        cycles(10000);
        check("tone_low", speak, 0);
        cycles(10010);
        check("tone_high", speak, 1);
        on = 1'b0;
        #1;
        check("tone_off", speak, 0);
        on = 1'b1;
        for (int k = 1; k <= 6; k++) tick_at(4, 0, k);
        check("chime_t6", period, 20000);
        tick_at(4, 0, 7);
        check("chime_end", period, 0);
        for (int k = 1; k <= 5; k++) begin
            logic [31:0] exp_p;
            // second chime run to see the alternating pattern tick by tick
            if (k == 1) tick_at(4, 0, 0);
            tick_at(4, 0, k);
            exp_p = (k % 2 == 0) ? 20000 : 0;
            check($sformatf("chime_step%0d", k), period, exp_p);
        end
        press(1'b0, 1'b1);
        check("chime_stop", period, 0);

        // Entries 1 and 2 at 08:00: lowest index wins, preempts chime
        cfg_write(1, 8, 0, 1'b1);
        cfg_write(2, 8, 0, 1'b1);
        cfg_write(3, 8, 5, 1'b1);
        tick_at(8, 0, 0);
        check("dual_active", alarm_active, 1);
        check("dual_idx", active_idx, 1);
        check("dual_period", period, 113636);

        // Rewriting the snoozed entry does not cancel the snooze
        press(1'b1, 1'b0);
        cfg_write(1, 9, 0, 1'b0);
        cycles(2);
        check("cfgwr_snoozing", snoozing, 1);
        check("cfgwr_idx", active_idx, 1);

        // A new match preempts the snooze with its own index
        tick_at(8, 5, 0);
        check("preempt_active", alarm_active, 1);
        check("preempt_idx", active_idx, 3);
        check("preempt_period", period, 113636);
        press(1'b0, 1'b1);

        // Asynchronous reset mid-ring
        tick_at(8, 0, 0);
        check("pre_rst_idx", active_idx, 2);
        check("pre_rst_period", period, 113636);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_period", period, 0);
        check("mid_rst_speak", speak, 0);
        check("mid_rst_active", alarm_active, 0);
        check("mid_rst_idx", active_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(2);
        tick_at(8, 5, 0);
        check("post_rst_table", alarm_active, 0);
        check("post_rst_period", period, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
